uart_ram_dump: RTL and testbench

- UART transmitter that streams a window of system RAM out on serial_txd. It is the outbound counterpart of uart_prog_input.
- On a start pulse it reads the window one byte at a time and transmits each byte as 8N1, LSB first.
- For each byte it briefly requests the RAM port via ask_for_ram, so CPU stalls stay short (a few cycles per byte).
- Sits in top_easy6502 beside uart_prog_input and shares the RAM read-port mux and the CPU-stall path.

---
 rtl/uart_ram_dump_pkg.sv | 29 ++
 rtl/uart_ram_dump_tx_byte.sv | 79 +++++++
 rtl/uart_ram_dump.sv | 205 ++++++++++++++++++++
 tb/tb_uart_ram_dump.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ram_dump_pkg.sv
// uart_ram_dump_pkg
// Shared definitions for the RAM dump UART.
// - Default clock and baud settings, common with uart_prog_input.
// - Bit-period helper.
// - FSM state encoding used by uart_ram_dump.
package uart_ram_dump_pkg;

  localparam int CLK_FREQ_DEF   = 25125000;
  localparam int BAUD_DEF       = 57600;
  localparam int ADDR_WIDTH_DEF = 11;
  localparam int GRANT_WAIT_DEF = 2;

  // Clock cycles per serial bit. The division truncates, and no fractional
  // correction is applied.
  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    ADDR = 3'd2,
    CAPT = 3'd3,
    SEND = 3'd4,
    NEXT = 3'd5,
    FIN  = 3'd6
  } dump_state_e;

endpackage

// File: rtl/uart_ram_dump_tx_byte.sv
// uart_tx_byte
// Sends one byte as an 8N1 frame, LSB first. The start bit is driven on the
// cycle after load, and every bit is held for exactly BAUD_DIV cycles.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   load         accept data and begin a frame (ignored while tx_busy)
//   data[7:0]    byte to send, sampled on load
//   txd          serial output, idle high
//   tx_busy      a frame is in progress
//   tx_done      high on the last cycle of the stop bit
module uart_tx_byte #(
  parameter int BAUD_DIV = 436
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       txd,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int              CNT_W     = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] BAUD_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] BAUD_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  // Bit index 9 is the stop bit.
  localparam logic [3:0]       BIT_LAST  = 4'd9;

  logic [CNT_W-1:0] baud_cnt_r;
  logic [3:0]       bit_cnt_r;
  // Bits still to be sent after the one on txd. It holds {stop, d7..d0} at
  // load and back-fills with ones, so the stop bit arrives by shifting.
  logic [8:0]       shift_r;
  logic             txd_r;
  logic             busy_r;
  logic             bit_end_s;

  assign bit_end_s = busy_r && (baud_cnt_r == BAUD_LAST);

  // Frame sequencing: baud counter, bit counter and shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_cnt_r <= BAUD_ZERO;
      bit_cnt_r  <= 4'd0;
      shift_r    <= 9'h1FF;
      txd_r      <= 1'b1;
      busy_r     <= 1'b0;
    end else if (load && !busy_r) begin
      baud_cnt_r <= BAUD_ZERO;
      bit_cnt_r  <= 4'd0;
      shift_r    <= {1'b1, data};
      txd_r      <= 1'b0;
      busy_r     <= 1'b1;
    end else if (bit_end_s) begin
      baud_cnt_r <= BAUD_ZERO;
      if (bit_cnt_r == BIT_LAST) begin
        bit_cnt_r <= 4'd0;
        shift_r   <= 9'h1FF;
        txd_r     <= 1'b1;
        busy_r    <= 1'b0;
      end else begin
        bit_cnt_r <= bit_cnt_r + 4'd1;
        shift_r   <= {1'b1, shift_r[8:1]};
        txd_r     <= shift_r[0];
        busy_r    <= 1'b1;
      end
    end else if (busy_r) begin
      baud_cnt_r <= baud_cnt_r + BAUD_ONE;
    end else begin
      baud_cnt_r <= BAUD_ZERO;
    end
  end

  assign txd     = txd_r;
  assign tx_busy = busy_r;
  assign tx_done = bit_end_s && (bit_cnt_r == BIT_LAST);

endmodule

// File: rtl/uart_ram_dump.sv
// uart_ram_dump
// Streams a window of RAM out of serial_txd, one 8N1 byte at a time. For
// each byte it briefly takes the RAM read port (ask_for_ram), so CPU stalls
// last only GRANT_WAIT+2 cycles per byte.
// Ports:
//   clk          system clock (CLK_25M)
//   reset        synchronous, active-high reset
//   start        one-cycle pulse to begin a dump, accepted only when idle
//   base_addr    first RAM address, sampled on start
//   length       byte count 0 .. 2^ADDR_WIDTH, sampled on start
//   ask_for_ram  stall the CPU and take the RAM read port
//   ram_raddr    read address, meaningful while ask_for_ram is high
//   ram_rdata    RAM data, valid one cycle after ram_raddr
//   serial_txd   UART output, idle high
//   busy         dump in progress
//   done         one-cycle pulse at the end of a dump
module uart_ram_dump
  import uart_ram_dump_pkg::*;
#(
  parameter int CLK_FREQ   = CLK_FREQ_DEF,
  parameter int BAUD       = BAUD_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int GRANT_WAIT = GRANT_WAIT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  ask_for_ram,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [7:0]            ram_rdata,
  output logic                  serial_txd,
  output logic                  busy,
  output logic                  done
);

  localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
  localparam int WAIT_W   = $clog2(GRANT_WAIT + 1);

  localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(GRANT_WAIT - 1);
  localparam logic [WAIT_W-1:0]     WAIT_ZERO = {WAIT_W{1'b0}};
  localparam logic [WAIT_W-1:0]     WAIT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   REM_ZERO  = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   REM_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  dump_state_e           state_r;
  dump_state_e           next_state_s;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [ADDR_WIDTH:0]   remaining_r;
  logic [WAIT_W-1:0]     wait_cnt_r;
  logic [ADDR_WIDTH-1:0] raddr_r;
  logic                  ask_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  ask_s;
  logic                  busy_s;
  logic                  done_s;
  logic                  start_ok_s;
  logic                  tx_load_s;
  logic                  tx_txd_s;
  logic                  tx_busy_s;
  logic                  tx_done_s;

  // A start is only taken when idle and the transmitter has fully drained.
  assign start_ok_s = start && !tx_busy_s;

  // The byte is handed to the transmitter straight from the RAM data bus in
  // CAPT; the transmitter's shift register is the byte latch.
  assign tx_load_s = (state_r == CAPT);

  uart_tx_byte #(
    .BAUD_DIV (BAUD_DIV)
  ) u_tx (
    .clk     (clk),
    .reset   (reset),
    .load    (tx_load_s),
    .data    (ram_rdata),
    .txd     (tx_txd_s),
    .tx_busy (tx_busy_s),
    .tx_done (tx_done_s)
  );

  // State register plus registered outputs (decoded from the next state so
  // they line up with the state they describe).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      ask_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      ask_r   <= ask_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_ok_s) begin
          next_state_s = (length == REM_ZERO) ? FIN : REQ;
        end else begin
          next_state_s = IDLE;
        end
      end
      REQ: begin
        if (wait_cnt_r == WAIT_LAST) begin
          next_state_s = ADDR;
        end else begin
          next_state_s = REQ;
        end
      end
      ADDR: next_state_s = CAPT;
      CAPT: next_state_s = SEND;
      SEND: begin
        if (tx_done_s) begin
          next_state_s = NEXT;
        end else begin
          next_state_s = SEND;
        end
      end
      // remaining_r still holds the pre-decrement count here.
      NEXT: begin
        if (remaining_r == REM_ONE) begin
          next_state_s = FIN;
        end else begin
          next_state_s = REQ;
        end
      end
      FIN:     next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Output decode from the next state, registered above.
  always_comb begin
    ask_s  = 1'b0;
    busy_s = 1'b1;
    done_s = 1'b0;
    case (next_state_s)
      IDLE: busy_s = 1'b0;
      REQ, ADDR, CAPT: ask_s = 1'b1;
      SEND, NEXT: ask_s = 1'b0;
      FIN: done_s = 1'b1;
      default: busy_s = 1'b0;
    endcase
  end

  // Address, byte count, grant wait counter and the read address register.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_r      <= ADDR_ZERO;
      remaining_r <= REM_ZERO;
      wait_cnt_r  <= WAIT_ZERO;
      raddr_r     <= ADDR_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_ok_s && (length != REM_ZERO)) begin
            addr_r      <= base_addr;
            remaining_r <= length;
          end else begin
            addr_r      <= addr_r;
            remaining_r <= remaining_r;
          end
        end
        // Address wraps naturally at 2^ADDR_WIDTH.
        NEXT: begin
          addr_r      <= addr_r + ADDR_ONE;
          remaining_r <= remaining_r - REM_ONE;
        end
        default: begin
          addr_r      <= addr_r;
          remaining_r <= remaining_r;
        end
      endcase

      if ((state_r == REQ) && (next_state_s == REQ)) begin
        wait_cnt_r <= wait_cnt_r + WAIT_ONE;
      end else begin
        wait_cnt_r <= WAIT_ZERO;
      end

      if (next_state_s == ADDR) begin
        raddr_r <= addr_r;
      end else begin
        raddr_r <= raddr_r;
      end
    end
  end

  assign ask_for_ram = ask_r;
  assign ram_raddr   = raddr_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign serial_txd  = tx_txd_s;

endmodule

// File: tb/tb_uart_ram_dump.sv
`timescale 1ns/1ps
// Directed bench for uart_ram_dump. A background UART receiver decodes every
// frame on serial_txd and compares it against bytes queued when each dump
// was launched.
module tb_uart_ram_dump;

  localparam int AW   = 11;
  localparam int BD   = 25125000 / 57600;   // 436 cycles per bit
  localparam int HALF = BD / 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          ask_for_ram;
  logic [AW-1:0] ram_raddr;
  logic [7:0]    ram_rdata;
  logic          serial_txd;
  logic          busy;
  logic          done;

  logic [7:0]    mem [0:2047];

  int            checks = 0;
  int            failures = 0;
  logic [7:0]    exp_q[$];
  int            rx_cnt = 0;
  bit            rst_event = 1'b0;

  // Results of the most recent watch()
  int            ask_runs[$];
  logic [AW-1:0] run_addr[$];
  bit            hist[$];
  int            done_cnt;
  int            done_at;
  logic          done_busy;
  logic          post_busy;
  logic          post_done;
  bit            txd_low;
  bit            ask_seen;

  always #20 clk = ~clk;

  uart_ram_dump dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .length      (length),
    .ask_for_ram (ask_for_ram),
    .ram_raddr   (ram_raddr),
    .ram_rdata   (ram_rdata),
    .serial_txd  (serial_txd),
    .busy        (busy),
    .done        (done)
  );

  // Registered-read RAM model
  always @(posedge clk) ram_rdata <= mem[ram_raddr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  // Background receiver: detect the start bit, sample each bit mid-period.
  initial begin : uart_rx
    logic [7:0] rx;
    logic       sb;
    logic       stp;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && serial_txd === 1'b0) begin
        repeat (HALF) @(negedge clk);
        sb = serial_txd;
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge clk);
          rx[i] = serial_txd;
        end
        repeat (BD) @(negedge clk);
        stp = serial_txd;
        if (rst_event) begin
          rst_event = 1'b0;      // frame cut short by reset, nothing to compare
        end else begin
          rx_cnt++;
          check("rx_start_bit", 32'(sb), 32'd0);
          check("rx_stop_bit", 32'(stp), 32'd1);
          if (exp_q.size() == 0) check("rx_unexpected_byte", 32'(rx), 32'h100);
          else check("rx_byte", 32'(rx), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic launch(input logic [AW-1:0] b, input logic [AW:0] n);
    base_addr = b;
    length    = n;
    start     = 1'b1;
    for (int i = 0; i < int'(n); i++) exp_q.push_back(mem[11'(int'(b) + i)]);
  endtask

  // Follow a dump cycle by cycle until done (bounded), optionally poking a
  // second start pulse at cycle poke_at.
  task automatic watch(input int budget, input int poke_at,
                       input logic [AW-1:0] pb, input logic [AW:0] pl);
    int run;
    logic [AW-1:0] last_a;
    ask_runs.delete(); run_addr.delete(); hist.delete();
    done_cnt = 0; done_at = 0; done_busy = 1'b0; txd_low = 1'b0; ask_seen = 1'b0;
    run = 0; last_a = '0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      hist.push_back(serial_txd);
      if (serial_txd === 1'b0) txd_low = 1'b1;
      if (ask_for_ram === 1'b1) begin
        ask_seen = 1'b1;
        run++;
        last_a = ram_raddr;
      end else if (run != 0) begin
        ask_runs.push_back(run);
        run_addr.push_back(last_a);
        run = 0;
      end
      if (c == 1) start = 1'b0;
      if (c == poke_at) begin
        base_addr = pb; length = pl; start = 1'b1;
      end
      if (c == poke_at + 1) start = 1'b0;
      if (done === 1'b1) begin
        done_cnt++; done_at = c; done_busy = busy;
        break;
      end
    end
    check("done_seen", 32'(done_cnt), 32'd1);
    @(negedge clk);
    post_busy = busy;
    post_done = done;
  endtask

  initial begin : main
    int f;
    int end_i;
    int len;
    bit cur;
    int runs[$];

    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_txd", 32'(serial_txd), 32'd1);
    check("rst_ask", 32'(ask_for_ram), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_raddr", 32'(ram_raddr), 32'd0);

    // 1: two-byte dump
    mem[11'h200] = 8'hA5; mem[11'h201] = 8'h3C;
    launch(11'h200, 12'd2);
    watch(2 * 4400 + 100, 0, '0, '0);
    check("t1_ask_runs", 32'(ask_runs.size()), 32'd2);
    for (int i = 0; i < 2; i++) check("t1_ask_len", 32'(ask_runs[i]), 32'd4);
    check("t1_raddr0", 32'(run_addr[0]), 32'h200);
    check("t1_raddr1", 32'(run_addr[1]), 32'h201);
    check("t1_busy_at_done", 32'(done_busy), 32'd1);
    check("t1_busy_after", 32'(post_busy), 32'd0);
    check("t1_done_width", 32'(post_done), 32'd0);
    check("t1_q_empty", 32'(exp_q.size()), 32'd0);

    // 2: bit timing on byte 0x01
    mem[11'h010] = 8'h01;
    launch(11'h010, 12'd1);
    watch(4400 + 100, 0, '0, '0);
    f = -1;
    for (int i = 0; i < hist.size(); i++) if (hist[i] == 1'b0) begin f = i; break; end
    // cycles 1,2 REQ, 3 ADDR, 4 CAPT, start bit on cycle 5 (index 4)
    check("t2_start_latency", 32'(f), 32'd4);
    if (f < 0) f = 0;
    end_i = done_at - 3;     // done in FIN, preceded by NEXT
    check("t2_frame_len", 32'(end_i - f + 1), 32'd4360);
    runs.delete(); cur = hist[f]; len = 0;
    for (int i = f; i <= end_i && i < hist.size(); i++) begin
      if (hist[i] == cur) len++;
      else begin runs.push_back(len); cur = hist[i]; len = 1; end
    end
    runs.push_back(len);
    check("t2_run_count", 32'(runs.size()), 32'd4);
    check("t2_start_bit_len", 32'(runs[0]), 32'd436);
    check("t2_d0_len", 32'(runs[1]), 32'd436);
    check("t2_d1_d7_len", 32'(runs[2]), 32'd3052);
    check("t2_stop_len", 32'(runs[3]), 32'd436);
    check("t2_d0_value", 32'(hist[f + BD + HALF]), 32'd1);
    check("t2_q_empty", 32'(exp_q.size()), 32'd0);

    // 3: address wrap
    mem[11'h7FF] = 8'h11; mem[11'h000] = 8'h22; mem[11'h001] = 8'h33;
    launch(11'h7FF, 12'd3);
    watch(3 * 4400 + 100, 0, '0, '0);
    check("t3_ask_runs", 32'(ask_runs.size()), 32'd3);
    check("t3_raddr0", 32'(run_addr[0]), 32'h7FF);
    check("t3_raddr1", 32'(run_addr[1]), 32'h000);
    check("t3_raddr2", 32'(run_addr[2]), 32'h001);
    check("t3_q_empty", 32'(exp_q.size()), 32'd0);

    // 4: zero length
    launch(11'h123, 12'd0);
    watch(20, 0, '0, '0);
    check("t4_done_latency", 32'(done_at), 32'd1);
    check("t4_ask_never", 32'(ask_seen), 32'd0);
    check("t4_txd_high", 32'(txd_low), 32'd0);
    check("t4_busy_after", 32'(post_busy), 32'd0);

    // 5: second start mid-frame is ignored
    mem[11'h300] = 8'h5A; mem[11'h301] = 8'hC3;
    launch(11'h300, 12'd2);
    watch(2 * 4400 + 100, 1000, 11'h000, 12'd5);
    check("t5_ask_runs", 32'(ask_runs.size()), 32'd2);
    check("t5_raddr0", 32'(run_addr[0]), 32'h300);
    check("t5_raddr1", 32'(run_addr[1]), 32'h301);
    check("t5_q_empty", 32'(exp_q.size()), 32'd0);
    repeat (10) @(negedge clk);
    check("t5_stays_idle", 32'(busy), 32'd0);

    // 6: reset during the data bits of the first byte, then a fresh dump
    mem[11'h400] = 8'h96; mem[11'h401] = 8'h69; mem[11'h500] = 8'hE7;
    launch(11'h400, 12'd2);
    @(negedge clk);
    start = 1'b0;
    repeat (1500) @(negedge clk);
    check("t6_mid_frame_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    rst_event = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("t6_rst_txd", 32'(serial_txd), 32'd1);
    check("t6_rst_ask", 32'(ask_for_ram), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    repeat (4500) @(negedge clk);
    launch(11'h500, 12'd1);
    watch(4400 + 100, 0, '0, '0);
    check("t6_raddr", 32'(run_addr[0]), 32'h500);
    check("t6_q_empty", 32'(exp_q.size()), 32'd0);

    check("rx_total", 32'(rx_cnt), 32'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
